// File: rtl/div_iter.sv
// Iterative restoring divider, signed or unsigned, STEP quotient bits per cycle.
// Divide-by-zero and most-negative/-1 resolve in a single cycle.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             start,
  input  logic             cancel,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int ITER = WIDTH / STEP;
  localparam int CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] acc, qr, dvs;
  logic [WIDTH-1:0] acc_nx, qr_nx;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   part;
  logic [WIDTH+1:0] trial;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r;
  logic             a_neg, b_neg;
  logic             accept, is_zero, is_ovf;

  assign a_neg   = sign & dividend[WIDTH-1];
  assign b_neg   = sign & divisor[WIDTH-1];
  assign abs_a   = a_neg ? -dividend : dividend;
  assign abs_b   = b_neg ? -divisor : divisor;
  assign accept  = start & ~cancel;
  assign is_zero = (divisor == '0);
  assign is_ovf  = sign && (dividend == MIN_NEG)
                   && (divisor == '1);

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  // acc < dvs always holds, so a restored part fits back into WIDTH bits
  always_comb begin
    acc_nx = acc;
    qr_nx  = qr;
    part   = '0;
    trial  = '0;
    for (int i = 0; i < STEP; i++) begin
      part  = {acc_nx, qr_nx[WIDTH-1]};
      trial = {1'b0, part} - {2'b00, dvs};
      if (!trial[WIDTH+1])
        acc_nx = trial[WIDTH-1:0];
      else
        acc_nx = part[WIDTH-1:0];
      qr_nx = {qr_nx[WIDTH-2:0], ~trial[WIDTH+1]};
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept)
          state_nx = (is_zero || is_ovf) ? DONE : CALC;
      CALC:
        if (cancel)
          state_nx = IDLE;
        else if (cnt == LAST)
          state_nx = FIX;
      FIX:
        state_nx = cancel ? IDLE : DONE;
      DONE:
        if (ack || cancel)
          state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc         <= '0;
      qr          <= '0;
      dvs         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            acc   <= '0;
            qr    <= abs_a;
            dvs   <= abs_b;
            cnt   <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            unique case (1'b1)
              is_zero: begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
              end
              is_ovf: begin
                quotient  <= dividend;
                remainder <= '0;
                overflow  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          if (!cancel) begin
            acc <= acc_nx;
            qr  <= qr_nx;
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (!cancel) begin
            quotient  <= neg_q ? -qr : qr;
            remainder <= neg_r ? -acc : acc;
          end
        end
        DONE: begin
          if (ack || cancel) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
